// File: rtl/cpu_bus_harness.sv
`default_nettype none
// ============================================================================
// Module   : cpu_bus_harness
// Purpose  : Bus harness for the cpu core. It sequences the core's reset,
//            serves program and data reads from preloadable memories with
//            one-cycle registered latency, and logs data writes. It also
//            detects a halt write or a cycle timeout.
// Revision : 1.0 - initial release
// ============================================================================
module cpu_bus_harness #(
    parameter int                 DATA_W         = 32,
    parameter int                 ADDR_W         = 32,
    parameter int                 DEPTH          = 256,
    parameter int                 RESET_CYCLES   = 41,
    parameter int                 TIMEOUT_CYCLES = 208333,
    parameter logic [DATA_W-1:0]  DEFAULT_DATA   = DATA_W'(32'h22b4),
    parameter logic [DATA_W-1:0]  DEFAULT_PROG   = DATA_W'(32'h064f),
    parameter logic [ADDR_W-1:0]  HALT_ADDR      = {{(ADDR_W-2){1'b1}}, 2'b00}
) (
    input  logic                      CLK,
    input  logic                      reset,
    output logic                      cpu_reset,
    input  logic                      CS,
    input  logic                      WE,
    input  logic [ADDR_W-1:0]         ADDR,
    input  logic [DATA_W-1:0]         Data_BUS_WRITE,
    output logic [DATA_W-1:0]         Data_BUS_READ,
    input  logic                      CS_P,
    input  logic [ADDR_W-1:0]         ADDR_Prog,
    output logic [DATA_W-1:0]         Prog_BUS_READ,
    input  logic                      load_en,
    input  logic                      load_sel,
    input  logic [$clog2(DEPTH)-1:0]  load_addr,
    input  logic [DATA_W-1:0]         load_data,
    output logic [31:0]               cycle_count,
    output logic [31:0]               wr_count,
    output logic [ADDR_W-1:0]         last_wr_addr,
    output logic [DATA_W-1:0]         last_wr_data,
    output logic                      halted,
    output logic                      timed_out
);

    localparam int IDX_W = $clog2(DEPTH);

    typedef enum logic [1:0] {
        S_HOLD    = 2'd0,
        S_RUN     = 2'd1,
        S_HALT    = 2'd2,
        S_TIMEOUT = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [31:0]         r_hold_cnt;
    logic [DATA_W-1:0]   r_dmem [DEPTH];
    logic [DATA_W-1:0]   r_pmem [DEPTH];

    logic [IDX_W-1:0]    w_d_idx;
    logic [IDX_W-1:0]    w_p_idx;
    logic                w_d_inr;
    logic                w_p_inr;
    logic                w_run;
    logic                w_wr;
    logic                w_halt_wr;
    logic                w_tmo;
    logic                w_dm_we;
    logic [IDX_W-1:0]    w_dm_addr;
    logic [DATA_W-1:0]   w_dm_wdata;
    logic                w_unused_ok;

    // Word index decode; byte-offset bits are deliberately ignored.
    assign w_d_idx     = ADDR[IDX_W+1:2];
    assign w_p_idx     = ADDR_Prog[IDX_W+1:2];
    assign w_unused_ok = ^{ADDR[1:0], ADDR_Prog[1:0]};

    // Upper address bits exist only when the memory is smaller than the bus
    // address space; otherwise every address is in range.
    generate
        if (IDX_W + 2 < ADDR_W) begin : g_range_chk
            assign w_d_inr = (ADDR[ADDR_W-1:IDX_W+2] == '0);
            assign w_p_inr = (ADDR_Prog[ADDR_W-1:IDX_W+2] == '0);
        end else begin : g_full_range
            assign w_d_inr = 1'b1;
            assign w_p_inr = 1'b1;
        end
    endgenerate

    assign w_run     = (r_state == S_RUN);
    assign w_wr      = w_run && CS && WE;
    assign w_halt_wr = w_wr && (ADDR == HALT_ADDR);
    assign w_tmo     = w_run && (cycle_count == 32'(TIMEOUT_CYCLES - 1));

    // State register; harness reset always returns to HOLD.
    always_ff @(posedge CLK) begin
        if (reset) begin
            r_state <= S_HOLD;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic and core reset; halt takes priority over timeout.
    always_comb begin
        w_next    = r_state;
        cpu_reset = 1'b1;
        case (r_state)
            S_HOLD: begin
                if (r_hold_cnt == 32'(RESET_CYCLES - 1)) begin
                    w_next = S_RUN;
                end
            end
            S_RUN: begin
                cpu_reset = 1'b0;
                if (w_halt_wr) begin
                    w_next = S_HALT;
                end else if (w_tmo) begin
                    w_next = S_TIMEOUT;
                end
            end
            default: begin
                w_next = r_state;
            end
        endcase
    end

    // Counts HOLD cycles to time the release of the core reset.
    always_ff @(posedge CLK) begin
        if (reset) begin
            r_hold_cnt <= '0;
        end else if (r_state == S_HOLD) begin
            r_hold_cnt <= r_hold_cnt + 32'd1;
        end
    end

    // RUN-cycle counter, write log and sticky termination flags.
    always_ff @(posedge CLK) begin
        if (reset) begin
            cycle_count  <= '0;
            wr_count     <= '0;
            last_wr_addr <= '0;
            last_wr_data <= '0;
            halted       <= 1'b0;
            timed_out    <= 1'b0;
        end else if (w_run) begin
            cycle_count <= cycle_count + 32'd1;
            if (w_wr) begin
                last_wr_addr <= ADDR;
                last_wr_data <= Data_BUS_WRITE;
                if (wr_count != 32'hFFFF_FFFF) begin
                    wr_count <= wr_count + 32'd1;
                end
            end
            if (w_halt_wr) begin
                halted <= 1'b1;
            end else if (w_tmo) begin
                timed_out <= 1'b1;
            end
        end
    end

    // Single data-memory write port: preload in HOLD, bus writes in RUN.
    always_comb begin
        w_dm_we    = 1'b0;
        w_dm_addr  = w_d_idx;
        w_dm_wdata = Data_BUS_WRITE;
        if ((r_state == S_HOLD) && load_en && load_sel) begin
            w_dm_we    = 1'b1;
            w_dm_addr  = load_addr;
            w_dm_wdata = load_data;
        end else if (w_wr && w_d_inr) begin
            w_dm_we = 1'b1;
        end
    end

    // Memory arrays; contents are never cleared by reset.
    always_ff @(posedge CLK) begin
        if (w_dm_we) begin
            r_dmem[w_dm_addr] <= w_dm_wdata;
        end
        if ((r_state == S_HOLD) && load_en && !load_sel) begin
            r_pmem[load_addr] <= load_data;
        end
    end

    // Registered read ports; read-during-write returns the old word.
    always_ff @(posedge CLK) begin
        if (reset) begin
            Data_BUS_READ <= DEFAULT_DATA;
            Prog_BUS_READ <= DEFAULT_PROG;
        end else begin
            Data_BUS_READ <= (w_run && CS && !WE && w_d_inr) ? r_dmem[w_d_idx] : DEFAULT_DATA;
            Prog_BUS_READ <= (w_run && CS_P && w_p_inr) ? r_pmem[w_p_idx] : DEFAULT_PROG;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cpu_bus_harness.sv
`default_nettype none
// ============================================================================
// Module   : tb_cpu_bus_harness
// Purpose  : Directed self-checking bench for cpu_bus_harness with
//            RESET_CYCLES=4 and TIMEOUT_CYCLES=20.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cpu_bus_harness;

    logic        CLK = 1'b0;
    logic        reset;
    logic        cpu_reset;
    logic        CS, WE, CS_P;
    logic [31:0] ADDR, Data_BUS_WRITE, Data_BUS_READ;
    logic [31:0] ADDR_Prog, Prog_BUS_READ;
    logic        load_en, load_sel;
    logic [7:0]  load_addr;
    logic [31:0] load_data;
    logic [31:0] cycle_count, wr_count, last_wr_addr, last_wr_data;
    logic        halted, timed_out;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    localparam logic [31:0] DD = 32'h0000_22b4;
    localparam logic [31:0] DP = 32'h0000_064f;

    cpu_bus_harness #(
        .DATA_W(32), .ADDR_W(32), .DEPTH(256),
        .RESET_CYCLES(4), .TIMEOUT_CYCLES(20)
    ) dut (
        .CLK(CLK), .reset(reset), .cpu_reset(cpu_reset),
        .CS(CS), .WE(WE), .ADDR(ADDR),
        .Data_BUS_WRITE(Data_BUS_WRITE), .Data_BUS_READ(Data_BUS_READ),
        .CS_P(CS_P), .ADDR_Prog(ADDR_Prog), .Prog_BUS_READ(Prog_BUS_READ),
        .load_en(load_en), .load_sel(load_sel), .load_addr(load_addr),
        .load_data(load_data),
        .cycle_count(cycle_count), .wr_count(wr_count),
        .last_wr_addr(last_wr_addr), .last_wr_data(last_wr_data),
        .halted(halted), .timed_out(timed_out)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        CS = 0; WE = 0; CS_P = 0; load_en = 0;
    endtask

    // Releases reset, checks the 4-cycle hold window, ends in RUN.
    task automatic release_to_run(input string tag);
        reset = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk({tag, "_hold_cpu_reset"}, cpu_reset, 1);
        end
        step();
        chk({tag, "_run_cpu_reset"}, cpu_reset, 0);
        chk({tag, "_run_cc"}, cycle_count, 0);
    endtask

    initial begin
        reset = 1; idle();
        ADDR = 0; Data_BUS_WRITE = 0; ADDR_Prog = 0;
        load_sel = 0; load_addr = 0; load_data = 0;

        // Reset pulse of two cycles
        step(); step();
        chk("rst_cpu_reset", cpu_reset, 1);
        chk("rst_data_bus", Data_BUS_READ, DD);
        chk("rst_prog_bus", Prog_BUS_READ, DP);
        chk("rst_cc", cycle_count, 0);
        chk("rst_wrc", wr_count, 0);
        chk("rst_lwa", last_wr_addr, 0);
        chk("rst_lwd", last_wr_data, 0);
        chk("rst_halted", halted, 0);
        chk("rst_timed_out", timed_out, 0);

        // HOLD with preloads: prog[3], data[5], data[255]
        reset = 0;
        load_en = 1; load_sel = 0; load_addr = 8'd3; load_data = 32'h2008_0005;
        step(); chk("hold1_cpu_reset", cpu_reset, 1);
        load_sel = 1; load_addr = 8'd5; load_data = 32'h1111_2222;
        step(); chk("hold2_cpu_reset", cpu_reset, 1);
        load_addr = 8'd255; load_data = 32'h0BAD_F00D;
        step(); chk("hold3_cpu_reset", cpu_reset, 1);
        chk("hold_prog_bus", Prog_BUS_READ, DP);
        load_en = 0;
        step(); chk("run_cpu_reset", cpu_reset, 0);
        chk("run_cc0", cycle_count, 0);

        // Program fetch, in range then out of range
        CS_P = 1; ADDR_Prog = 32'h0C;
        step(); chk("fetch_in", Prog_BUS_READ, 32'h2008_0005);
        ADDR_Prog = 32'h40C;
        step(); chk("fetch_oor", Prog_BUS_READ, DP);
        CS_P = 0;

        // Data write then readback
        CS = 1; WE = 1; ADDR = 32'h10; Data_BUS_WRITE = 32'hDEAD_BEEF;
        step();
        chk("wr1_count", wr_count, 1);
        chk("wr1_addr", last_wr_addr, 32'h10);
        chk("wr1_data", last_wr_data, 32'hDEAD_BEEF);
        WE = 0;
        step(); chk("rd_10", Data_BUS_READ, 32'hDEAD_BEEF);
        ADDR = 32'h15;
        step(); chk("rd_preload_15", Data_BUS_READ, 32'h1111_2222);

        // Overwrite: write cycle drives default, next read sees new word
        WE = 1; ADDR = 32'h10; Data_BUS_WRITE = 32'hCAFE_F00D;
        step();
        chk("wr2_count", wr_count, 2);
        chk("wr2_bus_default", Data_BUS_READ, DD);
        WE = 0;
        step(); chk("rd_new", Data_BUS_READ, 32'hCAFE_F00D);
        CS = 0;
        step(); chk("rd_idle_default", Data_BUS_READ, DD);
        chk("cc8", cycle_count, 8);

        // Out-of-range write aliasing index 4: logged, memory untouched
        CS = 1; WE = 1; ADDR = 32'h410; Data_BUS_WRITE = 32'h0000_5555;
        step();
        chk("oor_wr_count", wr_count, 3);
        chk("oor_wr_addr", last_wr_addr, 32'h410);
        WE = 0; ADDR = 32'h10;
        step(); chk("oor_mem_intact", Data_BUS_READ, 32'hCAFE_F00D);
        chk("cc10", cycle_count, 10);

        // Halt write on RUN cycle 10
        WE = 1; ADDR = 32'hFFFF_FFFC; Data_BUS_WRITE = 32'h1;
        step();
        chk("halt_flag", halted, 1);
        chk("halt_cpu_reset", cpu_reset, 1);
        chk("halt_cc", cycle_count, 11);
        chk("halt_wr_count", wr_count, 4);
        chk("halt_lwa", last_wr_addr, 32'hFFFF_FFFC);
        chk("halt_tmo", timed_out, 0);
        // Bus and preload ignored while halted
        WE = 0; ADDR = 32'h10;
        load_en = 1; load_sel = 0; load_addr = 8'd3; load_data = 32'h0;
        step(); step();
        chk("halt_rd_default", Data_BUS_READ, DD);
        chk("halt_cc_frozen", cycle_count, 11);
        chk("halt_sticky", halted, 1);
        idle();

        // Reset; memory survives; run then abort at RUN cycle 5
        reset = 1; step();
        chk("rst2_halted", halted, 0);
        chk("rst2_cc", cycle_count, 0);
        chk("rst2_wrc", wr_count, 0);
        release_to_run("r2");
        CS = 1; WE = 0; ADDR = 32'h3FC;
        step(); chk("mem255_intact", Data_BUS_READ, 32'h0BAD_F00D);
        WE = 1; ADDR = 32'h20; Data_BUS_WRITE = 32'h7;
        step(); chk("r2_wr_count", wr_count, 1);
        CS = 0; WE = 0;
        step(); step(); step();
        chk("r2_cc5", cycle_count, 5);
        CS_P = 1; ADDR_Prog = 32'h0C;
        reset = 1; step();
        chk("abort_cc", cycle_count, 0);
        chk("abort_wrc", wr_count, 0);
        chk("abort_lwa", last_wr_addr, 0);
        chk("abort_lwd", last_wr_data, 0);
        chk("abort_cpu_reset", cpu_reset, 1);
        chk("abort_prog_default", Prog_BUS_READ, DP);
        chk("abort_data_default", Data_BUS_READ, DD);
        CS_P = 0;
        release_to_run("r3");
        CS_P = 1; ADDR_Prog = 32'h0C;
        step(); chk("refetch_preload", Prog_BUS_READ, 32'h2008_0005);
        CS_P = 0;

        // Timeout: cc now 1, reach 19 then one more cycle
        repeat (18) step();
        chk("pre_tmo_cc", cycle_count, 19);
        chk("pre_tmo_flag", timed_out, 0);
        step();
        chk("tmo_flag", timed_out, 1);
        chk("tmo_cc", cycle_count, 20);
        chk("tmo_cpu_reset", cpu_reset, 1);
        chk("tmo_halted", halted, 0);
        step();
        chk("tmo_cc_frozen", cycle_count, 20);

        // Halt on RUN cycle 19 wins over timeout
        reset = 1; step();
        chk("rst4_tmo", timed_out, 0);
        release_to_run("r4");
        repeat (19) step();
        chk("pri_cc19", cycle_count, 19);
        CS = 1; WE = 1; ADDR = 32'hFFFF_FFFC; Data_BUS_WRITE = 32'h1;
        step();
        chk("pri_halted", halted, 1);
        chk("pri_timed_out", timed_out, 0);
        chk("pri_cc", cycle_count, 20);
        idle();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
